// File: rtl/lsc_pkg.sv
// Shared widths and helpers for the lens-shading-correction stream.
// Functions return 64-bit values; callers size-cast to their local widths.
package lsc_pkg;

    localparam int DEF_CHANNELS   = 3;
    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_GAIN_WIDTH = 12;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_CNT_WIDTH  = 24;

    // Half-LSB of the fractional part; zero when the gain is a pure integer.
    function automatic logic [63:0] round_const(input int frac_bits);
        return (frac_bits == 0) ? 64'd0 : (64'd1 << (frac_bits - 1));
    endfunction

    function automatic logic [63:0] max_pixel(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    // Channel 0 occupies the most significant lane of a packed word.
    function automatic int lane_lsb(input int lane, input int channels, input int width);
        return (channels - 1 - lane) * width;
    endfunction

endpackage

// File: rtl/lsc_lane.sv
// One colour channel: multiply by gain, round half-up and rescale, clamp.
// Stage registers advance only on the load strobes issued by the parent.
module lsc_lane
    import lsc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load1,
    input  logic                  load2,
    input  logic                  load3,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic                  bypass2,
    input  logic [DATA_WIDTH-1:0] raw2,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  sat
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH;
    localparam int RW = PW + 1 - FRAC_BITS;
    localparam logic [PW:0]           ROUND = (PW + 1)'(round_const(FRAC_BITS));
    localparam logic [RW-1:0]         MAX_R = RW'(max_pixel(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MAX_D = DATA_WIDTH'(max_pixel(DATA_WIDTH));

    logic [PW-1:0] product_reg;
    logic [RW-1:0] scaled_reg;
    logic [RW-1:0] scaled;
    logic          over;

    // Extra top bit on the rounding adder keeps the largest product from wrapping.
    assign scaled = RW'(({1'b0, product_reg} + ROUND) >> FRAC_BITS);
    assign over   = scaled_reg > MAX_R;

    always_ff @(posedge clock) begin
        if (load1) begin
            product_reg <= PW'(data) * PW'(gain);
        end
        if (load2) begin
            scaled_reg <= scaled;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result <= '0;
            sat    <= 1'b0;
        end else if (load3) begin
            result <= bypass2 ? raw2 : (over ? MAX_D : scaled_reg[DATA_WIDTH-1:0]);
            sat    <= ~bypass2 & over;
        end
    end

endmodule

// File: rtl/lsc_stream.sv
// Three-stage lens-shading-correction stream with valid/ready backpressure,
// per-beat bypass and per-frame saturation count.
module lsc_stream
    import lsc_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [CHANNELS*GAIN_WIDTH-1:0] in_gain,
    input  logic                           in_sof,
    input  logic                           in_bypass,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           out_sof,
    output logic [CNT_WIDTH-1:0]           sat_count
);

    localparam int NW = CHANNELS * DATA_WIDTH;
    localparam int CW = $clog2(CHANNELS + 1);

    logic valid1_reg, valid2_reg, valid3_reg;
    logic sof1_reg, sof2_reg, sof3_reg;
    logic bypass1_reg, bypass2_reg;
    logic [NW-1:0] raw1_reg, raw2_reg;
    logic [CNT_WIDTH-1:0] running_reg, running_next, sat_count_reg;

    logic ready1, ready2, ready3;
    logic load1, load2, load3;
    logic fire;
    logic [CHANNELS-1:0] lane_sat;
    logic [CW-1:0] clamp_count;
    logic [CNT_WIDTH:0] sum_wide;

    // A stage may take a new beat when empty or when its occupant moves on.
    assign ready3 = ~valid3_reg | out_ready;
    assign ready2 = ~valid2_reg | ready3;
    assign ready1 = ~valid1_reg | ready2;
    assign load1  = ready1 & in_valid;
    assign load2  = ready2 & valid1_reg;
    assign load3  = ready3 & valid2_reg;
    assign fire   = valid3_reg & out_ready;

    assign in_ready  = ready1;
    assign out_valid = valid3_reg;
    assign out_sof   = sof3_reg;
    assign sat_count = sat_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
            valid3_reg <= 1'b0;
            sof3_reg   <= 1'b0;
        end else begin
            if (ready1) valid1_reg <= in_valid;
            if (ready2) valid2_reg <= valid1_reg;
            if (ready3) valid3_reg <= valid2_reg;
            if (load3)  sof3_reg   <= sof2_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (load1) begin
            sof1_reg    <= in_sof;
            bypass1_reg <= in_bypass;
            raw1_reg    <= in_data;
        end
        if (load2) begin
            sof2_reg    <= sof1_reg;
            bypass2_reg <= bypass1_reg;
            raw2_reg    <= raw1_reg;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        localparam int DLSB = lane_lsb(gi, CHANNELS, DATA_WIDTH);
        localparam int GLSB = lane_lsb(gi, CHANNELS, GAIN_WIDTH);

        lsc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .GAIN_WIDTH (GAIN_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .load1   (load1),
            .load2   (load2),
            .load3   (load3),
            .data    (in_data[DLSB +: DATA_WIDTH]),
            .gain    (in_gain[GLSB +: GAIN_WIDTH]),
            .bypass2 (bypass2_reg),
            .raw2    (raw2_reg[DLSB +: DATA_WIDTH]),
            .result  (out_data[DLSB +: DATA_WIDTH]),
            .sat     (lane_sat[gi])
        );
    end

    always_comb begin
        clamp_count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            clamp_count = clamp_count + CW'(lane_sat[i]);
        end
    end

    // Running total sticks at all-ones instead of wrapping.
    assign sum_wide     = {1'b0, running_reg} + (CNT_WIDTH + 1)'(clamp_count);
    assign running_next = sum_wide[CNT_WIDTH] ? '1 : sum_wide[CNT_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            running_reg   <= '0;
            sat_count_reg <= '0;
        end else if (fire) begin
            if (sof3_reg) begin
                sat_count_reg <= running_reg;
                running_reg   <= CNT_WIDTH'(clamp_count);
            end else begin
                running_reg <= running_next;
            end
        end
    end

endmodule

// File: tb/tb_lsc_stream.sv
// Directed bench for lsc_stream: identity, rounding, throughput/bypass,
// backpressure, clamp statistics and mid-stream reset.
module tb_lsc_stream;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_data;
    logic [35:0] in_gain;
    logic        in_sof;
    logic        in_bypass;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_data;
    logic        out_sof;
    logic [23:0] sat_count;

    typedef struct {
        logic [35:0] data;
        logic        sof;
        logic        lat;
        time         t_acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    time  t_last_acc = 0;
    time  t_last_out = 0;
    logic        held_v = 1'b0;
    logic [35:0] held_d;
    logic        held_s;

    lsc_stream dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_gain   (in_gain),
        .in_sof    (in_sof),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .sat_count (sat_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [35:0] pk(input int a, input int b, input int c);
        return {a[11:0], b[11:0], c[11:0]};
    endfunction

    // Output monitor: every delivered beat is matched in order against the queue.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_data", out_data, held_d);
                check("stall_sof", out_sof, held_s);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_sof", out_sof, e.sof);
                    if (e.lat) check("latency", $time - e.t_acc, 30);
                    t_last_out = $time;
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_s = out_sof;
        end
    end

    // Present a beat from posedge+1; returns at posedge+1 after it is accepted.
    task automatic send(input logic [35:0] d, input logic [35:0] g, input logic sof,
                        input logic byp, input logic [35:0] e, input logic lat);
        exp_t x;
        int n;
        in_valid  = 1'b1;
        in_data   = d;
        in_gain   = g;
        in_sof    = sof;
        in_bypass = byp;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check("send_timeout", 0, 1);
        x.data = e; x.sof = sof; x.lat = lat; x.t_acc = $time;
        exp_q.push_back(x);
        t_last_acc = $time;
        @(posedge clock); #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_bypass = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock); #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    localparam logic [35:0] G1 = {12'd256, 12'd256, 12'd256};

    initial begin
        time t_first;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_gain = '0;
        in_sof = 1'b0; in_bypass = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_in_ready", in_ready, 1);

        // Identity with latency measurement.
        send(pk(1000, 1000, 1000), G1, 1'b0, 1'b0, pk(1000, 1000, 1000), 1'b1);
        idle();
        drain();

        // Rounding half-up, gain 0, exact full-scale.
        send(pk(1001, 1, 1), {12'd384, 12'd128, 12'd127}, 1'b0, 1'b0, pk(1502, 1, 0), 1'b1);
        send(pk(4095, 4095, 1234), {12'd0, 12'd256, 12'd256}, 1'b0, 1'b0, pk(0, 4095, 1234), 1'b0);
        idle();
        drain();

        // 100 back-to-back beats, odd ones bypassed with a gain that would clamp.
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 1)
                send(pk(2000 + i, 3000 - i, 4095 - i), {3{12'd4095}}, 1'b0, 1'b1,
                     pk(2000 + i, 3000 - i, 4095 - i), 1'b0);
            else
                send(pk(i * 37, i * 11, 4095 - i * 5), G1, 1'b0, 1'b0,
                     pk(i * 37, i * 11, 4095 - i * 5), 1'b0);
            if (i == 0) t_first = t_last_acc;
        end
        idle();
        drain();
        check("throughput_span", t_last_out - t_first, 1020);
        send(pk(5, 5, 5), G1, 1'b1, 1'b0, pk(5, 5, 5), 1'b0);
        idle();
        drain();
        check("bypass_no_sat", sat_count, 0);

        // Backpressure: 5 cycles of out_ready=0 while 6 beats are offered.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(pk(100 + i, 200 + i, 300 + i), G1, 1'b0, 1'b0,
                         pk(100 + i, 200 + i, 300 + i), 1'b0);
                idle();
            end
            begin
                out_ready = 1'b0;
                repeat (4) @(negedge clock);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                repeat (2) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Frame A with two clamped channels, then the sof of frame B.
        send(pk(10, 20, 30), G1, 1'b1, 1'b0, pk(10, 20, 30), 1'b0);
        send(pk(4000, 100, 4000), {12'd512, 12'd256, 12'd512}, 1'b0, 1'b0, pk(4095, 100, 4095), 1'b0);
        send(pk(4095, 0, 4095), {12'd256, 12'd0, 12'd256}, 1'b0, 1'b0, pk(4095, 0, 4095), 1'b0);
        send(pk(2048, 2048, 2048), {3{12'd128}}, 1'b0, 1'b0, pk(1024, 1024, 1024), 1'b0);
        idle();
        drain();
        check("frame_a_sat_prev", sat_count, 0);
        send(pk(1, 2, 3), G1, 1'b1, 1'b0, pk(1, 2, 3), 1'b0);
        idle();
        drain();
        check("frame_a_sat_count", sat_count, 2);

        // Reset with three beats held in the pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(pk(50 + i, 60 + i, 70 + i), G1, 1'b1, 1'b0, pk(50 + i, 60 + i, 70 + i), 1'b0);
        idle();
        check("pre_reset_out_valid", out_valid, 1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sat_count", sat_count, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_in_ready", in_ready, 1);
        send(pk(7, 8, 9), G1, 1'b0, 1'b0, pk(7, 8, 9), 1'b1);
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
